// File: rtl/issue_pkg.sv
// Shared issue-buffer definitions: geometry and the {pc,tag} entry record.
`ifndef XLEN
`define XLEN 32
`endif

package issue_pkg;
  localparam int ISSUE_DEPTH = 16;
  localparam int ISSUE_TAG_W = 6;
  localparam int ISSUE_CNT_W = $clog2(ISSUE_DEPTH + 1);

  typedef struct packed {
    logic [`XLEN-1:0]       pc;
    logic [ISSUE_TAG_W-1:0] tag;
  } issue_entry_t;
endpackage

// File: rtl/issue_req_buf_free_slot_enc.sv
// Lowest-index free-slot finder: one-hot of the first clear bit in 'used'.
module free_slot_enc #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0] used,
  output logic [DEPTH-1:0] free_oh,
  output logic             any_free
);
  always_comb begin
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!used[i] && free_oh == '0) free_oh[i] = 1'b1;
  end

  assign any_free = ~&used;
endmodule

// File: rtl/issue_req_buf.sv
// Requester-side buffer for the PC-ordered selector: entry array, registered
// output slot with valid/ready, and occupancy counter.
module issue_req_buf
  import issue_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH,
  parameter int TAG_W = ISSUE_TAG_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`XLEN-1:0]            in_pc,
  input  logic [TAG_W-1:0]            in_tag,
  output logic [DEPTH-1:0]            sel_req,
  output logic [DEPTH-1:0][`XLEN-1:0] sel_pc,
  output logic                        sel_en,
  input  logic [DEPTH-1:0]            sel_gnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`XLEN-1:0]            out_pc,
  output logic [TAG_W-1:0]            out_tag,
  output logic [CNT_W-1:0]            count
);
  logic [DEPTH-1:0] valid;
  issue_entry_t     ent [DEPTH];
  logic [DEPTH-1:0] alloc_oh, gnt_v;
  logic             any_free, in_fire, gnt_fire;
  issue_entry_t     gnt_ent;

  free_slot_enc #(.DEPTH(DEPTH)) u_free (
    .used    (valid),
    .free_oh (alloc_oh),
    .any_free(any_free)
  );

  // in_ready is purely occupancy-based; a slot freed by this cycle's grant
  // is not reusable until the next cycle.
  assign in_ready = reset & ~squash & (count != CNT_W'(DEPTH));
  assign in_fire  = in_valid & in_ready & any_free;
  assign sel_en   = ~out_valid | out_ready;
  assign sel_req  = valid;
  assign gnt_v    = sel_gnt & valid;
  assign gnt_fire = sel_en & (|gnt_v) & ~squash;

  always_comb begin
    gnt_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_pc[i] = valid[i] ? ent[i].pc : '0;
      if (gnt_v[i]) gnt_ent = gnt_ent | ent[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid     <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_tag   <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (squash) begin
      valid     <= '0;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      // Alloc targets a currently-free slot and grant a currently-valid one,
      // so the two never touch the same entry.
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt_fire && gnt_v[i]) valid[i] <= 1'b0;
        if (in_fire && alloc_oh[i]) begin
          valid[i] <= 1'b1;
          ent[i]   <= '{pc: in_pc, tag: in_tag};
        end
      end
      if (gnt_fire) begin
        out_valid <= 1'b1;
        out_pc    <= gnt_ent.pc;
        out_tag   <= gnt_ent.tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + CNT_W'(in_fire) - CNT_W'(gnt_fire);
    end
  end

  a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(sel_gnt));
endmodule

// File: tb/tb_issue_req_buf.sv
// Bench for issue_req_buf with a behavioural smallest-PC selector and a
// scoreboard queue of expected issued ops.
module tb_issue_req_buf;
  import issue_pkg::*;
  localparam int D = ISSUE_DEPTH;
  localparam int CW = ISSUE_CNT_W;

  logic                    clock = 1'b0;
  logic                    reset, squash, in_valid, in_ready;
  logic [`XLEN-1:0]        in_pc;
  logic [ISSUE_TAG_W-1:0]  in_tag;
  logic [D-1:0]            sel_req, sel_gnt;
  logic [D-1:0][`XLEN-1:0] sel_pc;
  logic                    sel_en, out_valid, out_ready;
  logic [`XLEN-1:0]        out_pc;
  logic [ISSUE_TAG_W-1:0]  out_tag;
  logic [CW-1:0]           count;

  int checks = 0, errors = 0;
  issue_entry_t exp_q[$];

  always #5 clock = ~clock;

  issue_req_buf dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_tag(in_tag),
    .sel_req(sel_req), .sel_pc(sel_pc), .sel_en(sel_en), .sel_gnt(sel_gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_tag(out_tag),
    .count(count)
  );

  // Selector stand-in: grant the requesting entry with the smallest PC.
  always_comb begin
    logic             found;
    logic [`XLEN-1:0] best;
    int               idx;
    sel_gnt = '0;
    found   = 1'b0;
    best    = '0;
    idx     = 0;
    for (int i = 0; i < D; i++)
      if (sel_req[i] && (!found || sel_pc[i] < best)) begin
        found = 1'b1; best = sel_pc[i]; idx = i;
      end
    if (found) sel_gnt[idx] = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      issue_entry_t e;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got pc %0h tag %0h expected none", out_pc, out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc", 64'(out_pc), 64'(e.pc));
        chk("issue_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  task automatic expect_op(input logic [`XLEN-1:0] pc, input logic [ISSUE_TAG_W-1:0] tag);
    exp_q.push_back('{pc: pc, tag: tag});
  endtask

  task automatic dispatch(input logic [`XLEN-1:0] pc, input logic [ISSUE_TAG_W-1:0] tag);
    in_valid = 1'b1; in_pc = pc; in_tag = tag;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; squash = 1'b0; in_valid = 1'b1; in_pc = 'h55; in_tag = 6'd5; out_ready = 1'b0;

    // 1: reset with dispatch attempted
    repeat (2) begin
      @(negedge clock);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_pc", 64'(out_pc), 0);
      chk("rst_count", 64'(count), 0);
      chk("rst_sel_req", 64'(sel_req), 0);
    end
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 64'(in_ready), 1);
    chk("post_rst_count", 64'(count), 0);
    cycles(1);

    // 2: streaming, each op issues on arrival
    out_ready = 1'b1;
    expect_op('h40, 1); expect_op('h10, 2); expect_op('h30, 3);
    dispatch('h40, 1); dispatch('h10, 2); dispatch('h30, 3);
    cycles(6);
    chk("t2_count", 64'(count), 0);
    chk("t2_drained", 64'(exp_q.size()), 0);

    // 3: preload behind a stalled output slot, then release
    out_ready = 1'b0;
    expect_op('h08, 9); expect_op('h10, 11); expect_op('h30, 12); expect_op('h40, 10);
    dispatch('h08, 9); dispatch('h40, 10); dispatch('h10, 11); dispatch('h30, 12);
    cycles(2);
    chk("t3_count", 64'(count), 3);
    chk("t3_hold_pc", 64'(out_pc), 'h08);
    out_ready = 1'b1;
    cycles(8);
    chk("t3_count_end", 64'(count), 0);
    chk("t3_drained", 64'(exp_q.size()), 0);

    // 4: fill to 16, drop an extra op, release
    out_ready = 1'b0;
    expect_op('h1000, 0);
    for (int k = 16; k >= 1; k--) expect_op(`XLEN'('h1000 - k * 4), 6'(k));
    for (int k = 0; k <= 16; k++) dispatch(`XLEN'('h1000 - k * 4), 6'(k));
    @(negedge clock);
    chk("t4_count_full", 64'(count), 16);
    chk("t4_in_ready_full", 64'(in_ready), 0);
    in_valid = 1'b1; in_pc = 'hDEAD; in_tag = 6'd63;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("t4_drop_count", 64'(count), 16);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("t4_in_ready_still0", 64'(in_ready), 0);
    @(negedge clock);
    chk("t4_in_ready_back", 64'(in_ready), 1);
    chk("t4_count_15", 64'(count), 15);
    cycles(20);
    chk("t4_count_end", 64'(count), 0);
    chk("t4_drained", 64'(exp_q.size()), 0);

    // 5: alloc and grant in the same cycle at count 15
    out_ready = 1'b0;
    expect_op('h800, 20);
    for (int k = 15; k >= 1; k--) expect_op(`XLEN'('h800 - k * 4), 6'(20 + k));
    expect_op('h2000, 50);
    for (int k = 0; k < 16; k++) dispatch(`XLEN'('h800 - k * 4), 6'(20 + k));
    @(negedge clock);
    chk("t5_count_pre", 64'(count), 15);
    chk("t5_req_pre", 64'(sel_req), 'h7FFF);
    @(posedge clock); #1;
    out_ready = 1'b1;
    dispatch('h2000, 50);
    @(negedge clock);
    chk("t5_count_keep", 64'(count), 15);
    chk("t5_req_post", 64'(sel_req), 'hBFFF);
    cycles(20);
    chk("t5_count_end", 64'(count), 0);
    chk("t5_drained", 64'(exp_q.size()), 0);

    // 6: squash with live entries, full output slot and a dispatch
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) dispatch(`XLEN'('h300 + k * 4), 6'(k));
    @(negedge clock);
    chk("t6_count_pre", 64'(count), 5);
    chk("t6_out_valid_pre", 64'(out_valid), 1);
    @(posedge clock); #1;
    squash = 1'b1; in_valid = 1'b1; in_pc = 'h777; in_tag = 6'd7;
    @(negedge clock);
    chk("t6_in_ready_sq", 64'(in_ready), 0);
    @(posedge clock); #1;
    squash = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("t6_count", 64'(count), 0);
    chk("t6_out_valid", 64'(out_valid), 0);
    chk("t6_sel_req", 64'(sel_req), 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    cycles(5);
    chk("t6_count_end", 64'(count), 0);
    chk("t6_out_valid_end", 64'(out_valid), 0);
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
